// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants, address/frame types and FSM state for the L1 instruction cache
package icache_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

  // Fetch address split into tag / frame index / ignored byte offset.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  // One cache frame: a single instruction word plus its tag and valid bit.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Split a fetch address using the default geometry.
  function automatic icachef_t icache_split(input logic [31:0] addr);
    return icachef_t'(addr);
  endfunction

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only L1 instruction cache; ICACHE_STATS_EN enables hit/miss counters
module icache
  import icache_pkg::*;
#(
  parameter int SETS     = ICACHE_SETS,
  parameter int PC_ALIGN = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - PC_ALIGN;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_bytoff;

  icache_state_t    state_q, state_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic hit;
  logic miss;
  logic fill_done;

  assign idx           = imemaddr[PC_ALIGN +: IDX_W];
  assign tag           = imemaddr[31 -: TAG_W];
  assign unused_bytoff = ^imemaddr[PC_ALIGN-1:0];

  assign hit = imemREN & valid_q[idx] & (tag_q[idx] == tag);

  // Fetch-side and memory-side outputs: hits are only reported from IDLE, fills only requested in FILL.
  always_comb begin
    ihit     = 1'b0;
    imemload = 32'd0;
    iREN     = 1'b0;
    iaddr    = 32'd0;
    if (state_q == IDLE) begin
      ihit = hit;
      if (hit) begin
        imemload = data_q[idx];
      end
    end else begin
      iREN  = 1'b1;
      iaddr = {imemaddr[31:PC_ALIGN], {PC_ALIGN{1'b0}}};
    end
  end

  // Next state: a miss starts a fill; a fill ends when memory answers or the fetch is withdrawn.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    miss      = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          miss    = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!iwait) begin
          fill_done    = 1'b1;
          valid_d[idx] = 1'b1;
          state_d      = IDLE;
        end else if (!imemREN) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and valid bits; reset invalidates every frame and aborts any fill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Frame payload capture; only qualified by valid, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Free-running wrap-around hit/miss statistics.
  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, ihit};
    miss_count_d = miss_count_q + {31'd0, miss};
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_miss;

  assign unused_miss = miss;
  assign hit_count   = 32'd0;
  assign miss_count  = 32'd0;
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache: vector table, corner sequences, randomized fetches vs model
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 CLK = ~CLK;

  icache dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .imemload   (imemload),
    .ihit       (ihit),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iload      (iload),
    .iwait      (iwait),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: contents indexed by word-address bits [5:2], tag = bits [31:6].
  bit          mv [16];
  logic [25:0] mt [16];
  logic [31:0] md [16];
  logic [31:0] mhits;
  logic [31:0] mmiss;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    bit          exp_hit;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a[31:2] == 30'h10) return 32'h2001_0005;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_counts(input string name);
`ifdef ICACHE_STATS_EN
    check({name, " hit_count"}, hit_count, mhits);
    check({name, " miss_count"}, miss_count, mmiss);
`else
    check({name, " hit_count"}, hit_count, 32'd0);
    check({name, " miss_count"}, miss_count, 32'd0);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    mhits = 32'd0;
    mmiss = 32'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete fetch: hit in one cycle, or miss + (lat busy cycles + 1 data cycle) of fill.
  task automatic fetch(input logic [31:0] a, input int lat, output bit was_hit);
    int          ix;
    logic [25:0] tg;
    ix       = int'(a[5:2]);
    tg       = a[31:6];
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = 32'hDEAD_BEEF;
    #1;
    was_hit = mv[ix] && (mt[ix] == tg);
    check("ihit lookup", 32'(ihit), 32'(was_hit));
    check("iREN lookup", 32'(iREN), 32'd0);
    if (was_hit) begin
      check("imemload", imemload, md[ix]);
      tick();
      mhits = mhits + 32'd1;
    end else begin
      tick();
      mmiss = mmiss + 32'd1;
      for (int k = 0; k <= lat; k++) begin
        iwait = (k < lat);
        iload = (k == lat) ? data_of(a) : 32'hDEAD_BEEF;
        #1;
        check("iREN fill", 32'(iREN), 32'd1);
        check("iaddr fill", iaddr, {a[31:2], 2'b00});
        check("ihit fill", 32'(ihit), 32'd0);
        tick();
      end
      mv[ix] = 1'b1;
      mt[ix] = tg;
      md[ix] = data_of(a);
    end
    imemREN = 1'b0;
    iwait   = 1'b1;
  endtask

  vec_t vecs [17];
  bit   h;

  initial begin
    vecs[0]  = '{32'h0000_0040, 3, 1'b0};
    vecs[1]  = '{32'h0000_0040, 0, 1'b1};
    vecs[2]  = '{32'h0000_0040, 0, 1'b1};
    vecs[3]  = '{32'h0000_0040, 0, 1'b1};
    vecs[4]  = '{32'h0000_0040, 0, 1'b1};
    vecs[5]  = '{32'h0000_0040, 0, 1'b1};
    vecs[6]  = '{32'h0000_0040, 0, 1'b1};
    vecs[7]  = '{32'h0000_0080, 1, 1'b0};
    vecs[8]  = '{32'h0000_0040, 2, 1'b0};
    vecs[9]  = '{32'h0000_0044, 0, 1'b0};
    vecs[10] = '{32'h0000_0044, 0, 1'b1};
    vecs[11] = '{32'h0000_0042, 0, 1'b1};
    vecs[12] = '{32'h0000_007C, 1, 1'b0};
    vecs[13] = '{32'hFFFF_FFFC, 0, 1'b0};
    vecs[14] = '{32'h0000_007C, 2, 1'b0};
    vecs[15] = '{32'h0000_007E, 0, 1'b1};
    vecs[16] = '{32'hFFFF_FFFC, 1, 1'b0};

    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = 32'd0;
    iwait    = 1'b1;
    iload    = 32'd0;
    model_reset();
    #12;
    check("reset ihit", 32'(ihit), 32'd0);
    check("reset iREN", 32'(iREN), 32'd0);
    check("reset iaddr", iaddr, 32'd0);
    check("reset imemload", imemload, 32'd0);
    check_counts("reset");
    nRST = 1'b1;
    tick();

    // Vector table: cold miss, repeated hits, conflicts, byte-offset aliasing.
    for (int i = 0; i < 17; i++) begin
      fetch(vecs[i].addr, vecs[i].lat, h);
      check($sformatf("vec%0d hit", i), 32'(h), 32'(vecs[i].exp_hit));
      if (i == 6) check_counts("after repeat hits");
    end
    check_counts("after table");

    // Abort: withdraw the fetch while memory is still busy; nothing may be written.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    iwait    = 1'b1;
    #1;
    check("abort lookup ihit", 32'(ihit), 32'd0);
    tick();
    mmiss = mmiss + 32'd1;
    check("abort fill iREN", 32'(iREN), 32'd1);
    tick();
    imemREN = 1'b0;
    #1;
    check("abort drop iREN", 32'(iREN), 32'd1);
    tick();
    check("abort idle iREN", 32'(iREN), 32'd0);
    check("abort idle ihit", 32'(ihit), 32'd0);
    fetch(32'h0000_0100, 1, h);
    check("abort refetch miss", 32'(h), 32'd0);

    // Fetch withdrawn in the very cycle memory answers: the fill still lands.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0148;
    #1;
    tick();
    mmiss   = mmiss + 32'd1;
    imemREN = 1'b0;
    iwait   = 1'b0;
    iload   = data_of(32'h0000_0148);
    #1;
    check("late drop iREN", 32'(iREN), 32'd1);
    tick();
    iwait = 1'b1;
    mv[2] = 1'b1;
    mt[2] = 26'h5;
    md[2] = data_of(32'h0000_0148);
    check("late drop idle iREN", 32'(iREN), 32'd0);
    fetch(32'h0000_0148, 0, h);
    check("late drop refetch hit", 32'(h), 32'd1);
    check_counts("after corners");

    // Reset in the middle of a fill.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0308;
    #1;
    tick();
    check("pre-reset iREN", 32'(iREN), 32'd1);
    nRST = 1'b0;
    #1;
    check("mid-fill reset iREN", 32'(iREN), 32'd0);
    check("mid-fill reset ihit", 32'(ihit), 32'd0);
    check("mid-fill reset iaddr", iaddr, 32'd0);
    model_reset();
    check_counts("mid-fill reset");
    imemREN = 1'b0;
    #1;
    nRST = 1'b1;
    tick();
    fetch(32'h0000_0044, 0, h);
    check("post-reset 0x44 miss", 32'(h), 32'd0);
    fetch(32'h0000_0148, 1, h);
    check("post-reset 0x148 miss", 32'(h), 32'd0);

    // Randomized fetch stream over a small tag pool to force hits and conflicts.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'hABC0_0000;
      fetch(a, int'($urandom_range(0, 3)), h);
      if (i % 25 == 0) check_counts($sformatf("random %0d", i));
    end
    check_counts("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
